chunk_adder_seq: RTL and testbench
==================================

Name: chunk_adder_seq

Overview:
- Multi-cycle wide adder built around one instance of the team's 4-bit ripple adder, fulladder4.
- Captures two W-bit operands on a start pulse and feeds them to the adder one 4-bit slice per cycle, LSB slice first.
- A carry register chains each slice's cout into the next slice's cin.
- Sits directly upstream of fulladder4 as its operand and carry sequencer. Gives wide addition at the gate cost of a single 4-bit adder.

Parameters:
- NCHUNK, 4, number of 4-bit slices; operand width W = 4*NCHUNK (default 16). Legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; accepted only when busy=0
- a  input  W  operand A; sampled on the accepting edge only
- b  input  W  operand B; sampled on the accepting edge only
- cin  input  1  carry-in to slice 0; sampled on the accepting edge only
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle completion strobe
- sum  output  W  registered result; held until the next completion
- cout  output  1  registered carry-out of the top slice; held with sum

Behaviour:
- Reset, synchronous and active-high, sampled on clk rise:
  - state=IDLE, slice index=0, carry register=0, internal accumulator=0.
  - sum=0, cout=0, done=0, busy=0.
  - Reset has priority over start and over any in-flight operation.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at edge T:
  - latch a, b, cin into internal registers; index←0; carry←cin.
  - state←RUN; busy=1 from T.
  - Otherwise remain in IDLE.
- RUN, at each edge T+k for k=1..NCHUNK:
  - slice i=k-1 is applied to fulladder4: a[4i+3:4i], b[4i+3:4i], cin=carry register.
  - The 4-bit result is written into accumulator bits [4i+3:4i]; carry←adder cout; index←index+1.
  - At edge T+NCHUNK (last slice): sum←full accumulator including the final slice; cout←final adder cout; state←DONE.
- DONE: done=1 and busy=0 for exactly one cycle (T+NCHUNK to T+NCHUNK+1); next edge → IDLE.
- start is ignored in RUN and in DONE; it is not queued.
- Latency: done asserts NCHUNK cycles after the accepting edge. Throughput is one operation per NCHUNK+2 cycles.
- sum and cout change only at the completion edge. Partial slice results are never visible on sum.
- a, b and cin may change freely after the accepting edge without affecting the result.
- Arithmetic: {cout,sum} = a + b + cin modulo 2^(W+1), unsigned. Overflow is reported only via cout.
- Reset mid-RUN: operation discarded; no done pulse; sum and cout return to 0.
- start and reset high on the same edge: reset wins; start is lost.

Optional Feature:
- Macro: CHUNK_ADDER_SEQ_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled together with a and b.
  - sub=1: latched b is inverted and the cin port is ignored; slice-0 carry starts at 1.
  - Result sum = a - b mod 2^W; cout=1 means no borrow (a ≥ b unsigned).
  - sub=0: identical to the base behaviour.
- Not defined: no sub port; addition only.

Test Plan:
- Reset, then a=16'h1234, b=16'h4321, cin=0, one-cycle start → done exactly 4 cycles after the accepting edge; sum=16'h5555, cout=0; busy high for 4 cycles.
- a=16'hFFFF, b=16'h0001, cin=0 → sum=16'h0000, cout=1. Confirms carry propagates across all four slices.
- a=16'hFFFF, b=16'h0000, cin=1 → sum=16'h0000, cout=1. Second case: a=16'h0ABC, b=16'h0000, cin=1 → sum=16'h0ABD, cout=0.
- Start 0x0001+0x0001; pulse start with 0x7000+0x7000 on the 2nd RUN cycle → second request ignored; sum=16'h0002, cout=0; only one done pulse.
- Complete 0x1111+0x1111 (sum=16'h2222). Start 0xF0F0+0x0F0F, assert reset on the 2nd RUN cycle → no done; next cycle sum=0, cout=0, busy=0. A fresh start is then accepted normally.
- With CHUNK_ADDER_SEQ_SUB_EN:
  - a=16'h0005, b=16'h0007, sub=1 → sum=16'hFFFE, cout=0.
  - a=16'h0007, b=16'h0005, sub=1 → sum=16'h0002, cout=1.

Source files
------------

// File: rtl/chunk_adder_seq.sv
// Multi-cycle W-bit adder that sequences operands through one 4-bit ripple adder, LSB slice first.
// Optional subtract mode is enabled by defining CHUNK_ADDER_SEQ_SUB_EN (adds the `sub` port).

module fulladder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    c[0] = cin;
    sum  = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end
endmodule

module chunk_adder_seq #(
  parameter int NCHUNK = 4,
  localparam int W = 4 * NCHUNK
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef CHUNK_ADDER_SEQ_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [3:0]       fa_a, fa_b, fa_sum;
  logic             fa_cout;
  logic             last_slice;

  assign fa_a       = a_q[{idx_q, 2'b00} +: 4];
  assign fa_b       = b_q[{idx_q, 2'b00} +: 4];
  assign last_slice = (idx_q == IDX_W'(NCHUNK - 1));

  fulladder4 u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on accept; one slice per RUN cycle, result published only on the last slice.
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
`ifdef CHUNK_ADDER_SEQ_SUB_EN
          if (sub) begin
            b_d     = ~b;
            carry_d = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        acc_d[{idx_q, 2'b00} +: 4] = fa_sum;
        carry_d = fa_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (last_slice) begin
          sum_d  = acc_d;
          cout_d = fa_cout;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_chunk_adder_seq.sv
// Self-checking bench for chunk_adder_seq: directed vector table, multi-cycle corner sequences,
// and randomized operations against an arithmetic reference model.

module tb_chunk_adder_seq;
  localparam int NCHUNK = 4;
  localparam int W = 4 * NCHUNK;

  logic         clk = 1'b0;
  logic         reset, start, cin, sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  chunk_adder_seq #(.NCHUNK(NCHUNK)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef CHUNK_ADDER_SEQ_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sb;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mci,
                       input logic msb, output logic [W-1:0] ms, output logic mc);
    logic [W:0] r;
    if (msb) begin
      r  = {1'b0, ma} - {1'b0, mb};
      ms = r[W-1:0];
      mc = (ma >= mb);
    end else begin
      r  = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mci};
      ms = r[W-1:0];
      mc = r[W];
    end
  endtask

  // Issue one operation, scramble the inputs after acceptance, and check latency, busy and result.
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tci, input logic tsb, input logic [W-1:0] es, input logic ec);
    int lat;
    int busy_cnt;
    @(negedge clk);
    a = ta; b = tb_v; cin = tci; sub = tsb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, NCHUNK);
    chk({tag, " busy_cycles"}, busy_cnt, NCHUNK);
    chk({tag, " busy_at_done"}, busy, 0);
    chk({tag, " sum"}, sum, es);
    chk({tag, " cout"}, cout, ec);
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, done, 0);
    sub = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ms;
    logic         mc;
    int           ndone;
    logic [W-1:0] cap_sum;
    logic         cap_cout;

    vecs.push_back('{a:16'h1234, b:16'h4321, ci:1'b0, sb:1'b0, es:16'h5555, ec:1'b0});
    vecs.push_back('{a:16'hFFFF, b:16'h0001, ci:1'b0, sb:1'b0, es:16'h0000, ec:1'b1});
    vecs.push_back('{a:16'hFFFF, b:16'h0000, ci:1'b1, sb:1'b0, es:16'h0000, ec:1'b1});
    vecs.push_back('{a:16'h0ABC, b:16'h0000, ci:1'b1, sb:1'b0, es:16'h0ABD, ec:1'b0});
    vecs.push_back('{a:16'hFFFF, b:16'hFFFF, ci:1'b1, sb:1'b0, es:16'hFFFF, ec:1'b1});
    vecs.push_back('{a:16'h0000, b:16'h0000, ci:1'b0, sb:1'b0, es:16'h0000, ec:1'b0});
`ifdef CHUNK_ADDER_SEQ_SUB_EN
    vecs.push_back('{a:16'h0005, b:16'h0007, ci:1'b0, sb:1'b1, es:16'hFFFE, ec:1'b0});
    vecs.push_back('{a:16'h0007, b:16'h0005, ci:1'b1, sb:1'b1, es:16'h0002, ec:1'b1});
    vecs.push_back('{a:16'h1234, b:16'h1234, ci:1'b0, sb:1'b1, es:16'h0000, ec:1'b1});
`endif

    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb,
            vecs[i].es, vecs[i].ec);

    // Start pulse during RUN must be ignored.
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 16'h7000; b = 16'h7000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; cap_sum = '1; cap_cout = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        ndone++;
        cap_sum = sum;
        cap_cout = cout;
      end
      @(posedge clk); #1;
    end
    chk("ignore_start done_count", ndone, 1);
    chk("ignore_start sum", cap_sum, 16'h0002);
    chk("ignore_start cout", cap_cout, 0);

    // Reset in the middle of RUN discards the operation.
    do_op("pre_reset", 16'h1111, 16'h1111, 1'b0, 1'b0, 16'h2222, 1'b0);
    @(negedge clk);
    a = 16'hF0F0; b = 16'h0F0F; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrun_reset sum", sum, 0);
    chk("midrun_reset cout", cout, 0);
    chk("midrun_reset busy", busy, 0);
    chk("midrun_reset done", done, 0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    chk("midrun_reset no_done", ndone, 0);

    // Reset and start together: reset wins.
    @(negedge clk);
    a = 16'h0003; b = 16'h0004; start = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    chk("reset_vs_start busy", busy, 0);

    do_op("post_reset", 16'h0ABC, 16'h1000, 1'b0, 1'b0, 16'h1ABC, 1'b0);

    for (int n = 0; n < 25; n++) begin
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef CHUNK_ADDER_SEQ_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      if (n % 5 == 0) ra = '1;
      model(ra, rb, rc, rs, ms, mc);
      do_op($sformatf("rand%0d", n), ra, rb, rc, rs, ms, mc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
